sum_accumulator: RTL and testbench

Downstream consumer of the 4-bit registered adder stage. It is driven by the same enable that drives the adder and samples the adder's registered {Overflow,Sum} one cycle after each enable. It adds the 5-bit values into a saturating running total over blocks of BLOCK_LEN results, then presents each block total on a valid/ready output handshake to the next stage.

---
 rtl/sum_accumulator_pkg.sv | 15 +
 rtl/sum_accumulator_sat_add.sv | 22 ++
 rtl/sum_accumulator.sv | 132 +++++++++++++
 tb/tb_sum_accumulator.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/sum_accumulator_pkg.sv
// Shared types and constants for the adder-side accumulation stages.
package sum_accumulator_pkg;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  // Sum width of the upstream 4-bit registered adder.
  localparam int DATA_W_DEF = 4;

  // Extra headroom bit used by sat_add_unit to detect overflow past ACC_W.
  localparam int SAT_ADD_GUARD = 1;

endpackage

// File: rtl/sum_accumulator_sat_add.sv
// Combinational saturating adder: ACC_W-bit running value plus a narrow sample.
module sat_add_unit
  import sum_accumulator_pkg::*;
#(
  parameter int ACC_W = 8,
  parameter int VAL_W = 5
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [VAL_W-1:0] val,
  output logic [ACC_W-1:0] result,
  output logic             sat
);

  localparam int TMP_W = ACC_W + SAT_ADD_GUARD;

  logic [TMP_W-1:0] tmp;

  assign tmp    = TMP_W'(acc) + TMP_W'(val);
  assign sat    = tmp[ACC_W];
  assign result = sat ? '1 : tmp[ACC_W-1:0];

endmodule

// File: rtl/sum_accumulator.sv
// Saturating block accumulator behind the registered adder; emits block totals
// on a valid/ready handshake.
module sum_accumulator
  import sum_accumulator_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ACC_W     = 8,
  parameter int BLOCK_LEN = 16,
  parameter int CNT_W     = $clog2(BLOCK_LEN + 1)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              En,
  input  logic [DATA_W-1:0] Sum,
  input  logic              Overflow,
  input  logic              Flush,
  input  logic              Out_Ready,
  output logic              Out_Valid,
  output logic [ACC_W-1:0]  Out_Total,
  output logic [CNT_W-1:0]  Out_Count,
  output logic              Out_Sat,
  output logic              Drop_Err
);

  localparam logic [CNT_W-1:0] BLK = CNT_W'(BLOCK_LEN);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc, acc_d, nacc, add_base, add_res;
  logic [CNT_W-1:0] count, cnt_d, ncnt;
  logic             sat, sat_d, nsat, add_sat;
  logic             en_d, present;
  logic             load, valid_d, drop_d;

  assign present  = en_d;
  // A sample accepted on the HOLD->ACCUM handoff starts a fresh block.
  assign add_base = (state_q == ST_HOLD) ? '0 : acc;

  sat_add_unit #(.ACC_W(ACC_W), .VAL_W(DATA_W + 1)) u_sat_add (
    .acc    (add_base),
    .val    ({Overflow, Sum}),
    .result (add_res),
    .sat    (add_sat)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc;
    cnt_d   = count;
    sat_d   = sat;
    nacc    = acc;
    ncnt    = count;
    nsat    = sat;
    load    = 1'b0;
    valid_d = Out_Valid;
    drop_d  = Drop_Err;
    case (state_q)
      ST_ACCUM: begin
        if (present) begin
          nacc = add_res;
          nsat = sat | add_sat;
          ncnt = count + CNT_W'(1);
        end
        if (ncnt == BLK || (Flush && ncnt != '0)) begin
          load    = 1'b1;
          valid_d = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
          state_d = ST_HOLD;
        end else begin
          acc_d = nacc;
          cnt_d = ncnt;
          sat_d = nsat;
        end
      end
      ST_HOLD: begin
        if (present && !Out_Ready) drop_d = 1'b1;
        if (Out_Ready) begin
          if (present) begin
            nacc = add_res;
            nsat = add_sat;
            ncnt = CNT_W'(1);
          end else begin
            nacc = '0;
            nsat = 1'b0;
            ncnt = '0;
          end
          // One-sample blocks complete immediately on the handoff sample.
          if (ncnt == BLK) begin
            load = 1'b1;
          end else begin
            valid_d = 1'b0;
            state_d = ST_ACCUM;
            acc_d   = nacc;
            cnt_d   = ncnt;
            sat_d   = nsat;
          end
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= ST_ACCUM;
      acc       <= '0;
      count     <= '0;
      sat       <= 1'b0;
      en_d      <= 1'b0;
      Out_Valid <= 1'b0;
      Out_Total <= '0;
      Out_Count <= '0;
      Out_Sat   <= 1'b0;
      Drop_Err  <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc       <= acc_d;
      count     <= cnt_d;
      sat       <= sat_d;
      en_d      <= En;
      Out_Valid <= valid_d;
      Drop_Err  <= drop_d;
      if (load) begin
        Out_Total <= nacc;
        Out_Count <= ncnt;
        Out_Sat   <= nsat;
      end
    end
  end

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: models the upstream registered adder and scoreboards block emissions.
module tb_sum_accumulator;

  logic       Clk = 1'b0;
  logic       Rst, En, Flush, Out_Ready;
  logic [3:0] a, b;
  logic [3:0] sum_q;
  logic       ov_q;
  logic       Out_Valid, Out_Sat, Drop_Err;
  logic [7:0] Out_Total;
  logic [4:0] Out_Count;

  typedef struct {
    int total;
    int count;
    int sat;
  } blk_t;

  blk_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 Clk = ~Clk;

  // Upstream 4-bit registered adder sharing En.
  always_ff @(posedge Clk) begin
    if (Rst) {ov_q, sum_q} <= 5'd0;
    else if (En) {ov_q, sum_q} <= 5'(a) + 5'(b);
  end

  sum_accumulator dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .En        (En),
    .Sum       (sum_q),
    .Overflow  (ov_q),
    .Flush     (Flush),
    .Out_Ready (Out_Ready),
    .Out_Valid (Out_Valid),
    .Out_Total (Out_Total),
    .Out_Count (Out_Count),
    .Out_Sat   (Out_Sat),
    .Drop_Err  (Drop_Err)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input int total, input int count, input int sat);
    blk_t e;
    e.total = total;
    e.count = count;
    e.sat   = sat;
    exp_q.push_back(e);
  endtask

  task automatic burst(input int n, input int va, input int vb);
    for (int i = 0; i < n; i++) begin
      En = 1'b1;
      a  = 4'(va);
      b  = 4'(vb);
      cyc();
    end
    En = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) cyc();
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  // Scoreboard: every completed handshake must match the next expected block.
  always @(negedge Clk) begin
    if (!Rst && Out_Valid && Out_Ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_emit", int'(Out_Total), -1);
      end else begin
        blk_t e;
        e = exp_q.pop_front();
        chk("blk_total", int'(Out_Total), e.total);
        chk("blk_count", int'(Out_Count), e.count);
        chk("blk_sat", int'(Out_Sat), e.sat);
      end
    end
  end

  initial begin
    Rst = 1'b1; En = 1'b0; Flush = 1'b0; Out_Ready = 1'b1; a = '0; b = '0;
    cyc(); cyc();
    Rst = 1'b0;
    chk("rst_valid", int'(Out_Valid), 0);
    chk("rst_total", int'(Out_Total), 0);
    chk("rst_count", int'(Out_Count), 0);
    chk("rst_sat", int'(Out_Sat), 0);
    chk("rst_drop", int'(Drop_Err), 0);

    // 1: 16 x 7, check 2-cycle latency from last En
    push(112, 16, 0);
    burst(16, 3, 4);
    chk("lat_n1_valid", int'(Out_Valid), 0);
    cyc();
    chk("lat_n2_valid", int'(Out_Valid), 1);
    drain();
    cyc();

    // 2: 16 x 30 saturates at 255
    push(255, 16, 1);
    burst(16, 15, 15);
    drain();
    cyc();

    // 3: 5 x 9 with Flush in the cycle of the 5th sample
    push(45, 5, 0);
    burst(5, 4, 5);
    Flush = 1'b1;
    cyc();
    Flush = 1'b0;
    drain();
    cyc(); cyc();
    Flush = 1'b1;
    cyc();
    Flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("empty_flush_valid", int'(Out_Valid), 0);
      cyc();
    end

    // 4: stall in HOLD while two samples arrive
    Out_Ready = 1'b0;
    push(32, 16, 0);
    burst(16, 1, 1);
    cyc();
    chk("hold_valid", int'(Out_Valid), 1);
    for (int k = 0; k < 4; k++) begin
      En = (k < 2);
      a  = 4'd1;
      b  = 4'd0;
      cyc();
      chk("hold_stable_valid", int'(Out_Valid), 1);
      chk("hold_stable_total", int'(Out_Total), 32);
      chk("hold_stable_count", int'(Out_Count), 16);
      chk("hold_stable_sat", int'(Out_Sat), 0);
    end
    En = 1'b0;
    chk("drop_err_set", int'(Drop_Err), 1);
    Out_Ready = 1'b1;
    cyc();
    chk("post_ready_valid", int'(Out_Valid), 0);
    push(16, 16, 0);
    burst(16, 1, 0);
    drain();
    chk("drop_err_sticky", int'(Drop_Err), 1);
    cyc();

    // 5: sample of 6 present on the Out_Ready cycle starts the next block
    Out_Ready = 1'b0;
    push(32, 16, 0);
    push(21, 16, 0);
    burst(16, 1, 1);
    burst(1, 2, 4);
    chk("hs_hold_valid", int'(Out_Valid), 1);
    Out_Ready = 1'b1;
    cyc();
    chk("hs_done_valid", int'(Out_Valid), 0);
    burst(15, 1, 0);
    drain();
    cyc();

    // 6: reset mid-block discards the partial block
    burst(10, 1, 0);
    Rst = 1'b1;
    cyc(); cyc();
    Rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_valid", int'(Out_Valid), 0);
      cyc();
    end
    chk("post_rst_drop", int'(Drop_Err), 0);
    push(16, 16, 0);
    burst(16, 1, 0);
    drain();
    chk("final_drop", int'(Drop_Err), 0);
    cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
